axis_snoop_arbiter: RTL and testbench

//   Passive AXI-Stream packet aggregator. Observes (snoops) up to 4 AXI-Stream links without

---
 rtl/axis_snoop_pkg.sv | 20 ++
 rtl/axis_snoop_pkt_fifo.sv | 106 ++++++++++
 rtl/axis_snoop_arbiter.sv | 144 ++++++++++++++
 tb/tb_axis_snoop_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_snoop_pkg.sv
// Shared definitions for the AXI-Stream snoop arbiter.
//   MAX_INTERFACES : number of snoop ports on the top level (fixed at 4)
//   arb_state_e    : merge FSM states (IDLE picks a channel, SEND drains one packet)
//   entry_width()  : width of one stored FIFO entry {tlast, tdata} for a data width
package axis_snoop_pkg;

  localparam int MAX_INTERFACES = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

  // The FIFO entry is {tlast, tdata}; the FIFO builds its packed entry type
  // from this width so the layout stays in one place.
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/axis_snoop_pkt_fifo.sv
// Per-channel store-and-forward packet FIFO.
// Beats are written at a speculative write pointer; a beat carrying tlast
// commits the packet by advancing the committed pointer and the packet count.
// If a beat arrives while the FIFO is full, the partial packet is rolled back
// and the remainder of that packet (through tlast) is discarded, so committed
// packets are never disturbed.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_beat               a snooped beat is present this cycle (tvalid && tready)
//   in_data, in_last      snooped tdata / tlast
//   pop                   consume the head entry (only issued on committed data)
//   head_data, head_last  head entry, combinational read
//   has_packet            at least one committed packet is stored
module axis_snoop_pkt_fifo
  import axis_snoop_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_beat,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_last,
  output logic         has_packet
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_width(W);

  typedef struct packed {
    logic         tlast;
    logic [W-1:0] tdata;
  } entry_t;

  entry_t       mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  committed_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  pkt_count;
  logic         dropping;
  logic         full;
  logic         wr_en;
  logic         commit;
  logic         pop_last;
  entry_t       head;
  logic [EW-1:0] head_bits;

  // Occupancy includes the uncommitted tail, so a long packet hits full.
  assign full     = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
  assign wr_en    = in_beat && !dropping && !full;
  assign commit   = wr_en && in_last;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_bits = head;
  assign pop_last = pop && head.tlast;

  assign head_data  = head_bits[W-1:0];
  assign head_last  = head_bits[W];
  assign has_packet = (pkt_count != '0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= '{tlast: in_last, tdata: in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      committed_ptr <= '0;
      rd_ptr        <= '0;
      dropping      <= 1'b0;
    end else begin
      if (in_beat) begin
        if (dropping) begin
          // Discard until the end of the overflowed packet.
          if (in_last) dropping <= 1'b0;
        end else if (full) begin
          wr_ptr   <= committed_ptr;
          dropping <= !in_last;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          if (in_last) committed_ptr <= wr_ptr + 1'b1;
        end
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Commit and completed pop on the same edge cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else begin
      case ({commit, pop_last})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: rtl/axis_snoop_arbiter.sv
// Passive AXI-Stream packet aggregator.
// Snoops up to four AXI-Stream links (never back-pressuring them), buffers
// complete packets per channel, and merges them round-robin onto one master
// stream without interleaving packets.
// Handshake: a snooped beat is captured on an edge where s0N tvalid && tready;
// an output beat transfers on an edge where m_axis_tvalid && m_axis_tready, and
// while m_axis_tready is low the output valid/data/last are held stable.
// Ports:
//   axis_aclk, axis_aresetn     clock, asynchronous active-low reset
//   s0N_axis_tvalid/tready/     snooped link N (all inputs)
//   tdata/tlast
//   m_axis_tvalid/tdata/tlast   merged stream (outputs)
//   m_axis_tready               merged stream back-pressure (input)
module axis_snoop_arbiter
  import axis_snoop_pkg::*;
#(
  parameter int NUM_INTERFACES = 2,
  parameter int PORT_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                  axis_aclk,
  input  logic                  axis_aresetn,
  input  logic                  s00_axis_tvalid,
  input  logic                  s00_axis_tready,
  input  logic [PORT_WIDTH-1:0] s00_axis_tdata,
  input  logic                  s00_axis_tlast,
  input  logic                  s01_axis_tvalid,
  input  logic                  s01_axis_tready,
  input  logic [PORT_WIDTH-1:0] s01_axis_tdata,
  input  logic                  s01_axis_tlast,
  input  logic                  s02_axis_tvalid,
  input  logic                  s02_axis_tready,
  input  logic [PORT_WIDTH-1:0] s02_axis_tdata,
  input  logic                  s02_axis_tlast,
  input  logic                  s03_axis_tvalid,
  input  logic                  s03_axis_tready,
  input  logic [PORT_WIDTH-1:0] s03_axis_tdata,
  input  logic                  s03_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [PORT_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast
);

  logic [MAX_INTERFACES-1:0] in_beat;
  logic [MAX_INTERFACES-1:0] in_last;
  logic [PORT_WIDTH-1:0]     in_data   [MAX_INTERFACES];
  logic [MAX_INTERFACES-1:0] has_pkt;
  logic [MAX_INTERFACES-1:0] head_last;
  logic [PORT_WIDTH-1:0]     head_data [MAX_INTERFACES];
  logic [MAX_INTERFACES-1:0] pop;

  arb_state_e state;
  logic [1:0] grant;
  logic [1:0] rr_ptr;
  logic [1:0] next_grant;
  logic [1:0] rr_next;
  logic       found;

  assign in_beat[0] = s00_axis_tvalid && s00_axis_tready;
  assign in_beat[1] = s01_axis_tvalid && s01_axis_tready;
  assign in_beat[2] = s02_axis_tvalid && s02_axis_tready;
  assign in_beat[3] = s03_axis_tvalid && s03_axis_tready;
  assign in_last    = {s03_axis_tlast, s02_axis_tlast, s01_axis_tlast, s00_axis_tlast};
  assign in_data[0] = s00_axis_tdata;
  assign in_data[1] = s01_axis_tdata;
  assign in_data[2] = s02_axis_tdata;
  assign in_data[3] = s03_axis_tdata;

  for (genvar i = 0; i < MAX_INTERFACES; i++) begin : g_ch
    if (i < NUM_INTERFACES) begin : g_on
      axis_snoop_pkt_fifo #(
        .W    (PORT_WIDTH),
        .DEPTH(FIFO_DEPTH)
      ) u_fifo (
        .clk       (axis_aclk),
        .rst_n     (axis_aresetn),
        .in_beat   (in_beat[i]),
        .in_data   (in_data[i]),
        .in_last   (in_last[i]),
        .pop       (pop[i]),
        .head_data (head_data[i]),
        .head_last (head_last[i]),
        .has_packet(has_pkt[i])
      );
    end else begin : g_off
      // Inactive channel: never has a packet, so it is never granted.
      assign has_pkt[i]   = 1'b0;
      assign head_last[i] = 1'b0;
      assign head_data[i] = '0;
    end
  end

  // Round-robin scan starting at rr_ptr, wrapping within the active channels.
  always_comb begin
    int idx;
    found      = 1'b0;
    next_grant = rr_ptr;
    idx        = 0;
    for (int k = 0; k < MAX_INTERFACES; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_INTERFACES;
      if (k < NUM_INTERFACES && !found && has_pkt[idx]) begin
        found      = 1'b1;
        next_grant = 2'(idx);
      end
    end
  end

  assign rr_next = 2'((int'(grant) + 1) % NUM_INTERFACES);

  always_comb begin
    pop = '0;
    if (state == SEND && m_axis_tready) pop[grant] = 1'b1;
  end

  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tdata  = (state == SEND) ? head_data[grant] : '0;
  assign m_axis_tlast  = (state == SEND) && head_last[grant];

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= next_grant;
            state <= SEND;
          end
        end
        SEND: begin
          if (m_axis_tready && head_last[grant]) begin
            rr_ptr <= rr_next;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_snoop_arbiter.sv
// Bench for axis_snoop_arbiter with NUM_INTERFACES=2, PORT_WIDTH=8, FIFO_DEPTH=16.
// A packet-level reference model (queues of committed beats per channel, the
// packet currently being merged, round-robin channel choice) predicts the
// output every cycle.
module tb_axis_snoop_arbiter;

  localparam int N     = 2;
  localparam int W     = 8;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         s_valid [4];
  logic         s_ready [4];
  logic         s_last  [4];
  logic [W-1:0] s_data  [4];
  logic         m_tready;
  logic         m_tvalid;
  logic [W-1:0] m_tdata;
  logic         m_tlast;

  axis_snoop_arbiter #(
    .NUM_INTERFACES(N),
    .PORT_WIDTH    (W),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .axis_aclk      (clk),
    .axis_aresetn   (rst_n),
    .s00_axis_tvalid(s_valid[0]),
    .s00_axis_tready(s_ready[0]),
    .s00_axis_tdata (s_data[0]),
    .s00_axis_tlast (s_last[0]),
    .s01_axis_tvalid(s_valid[1]),
    .s01_axis_tready(s_ready[1]),
    .s01_axis_tdata (s_data[1]),
    .s01_axis_tlast (s_last[1]),
    .s02_axis_tvalid(s_valid[2]),
    .s02_axis_tready(s_ready[2]),
    .s02_axis_tdata (s_data[2]),
    .s02_axis_tlast (s_last[2]),
    .s03_axis_tvalid(s_valid[3]),
    .s03_axis_tready(s_ready[3]),
    .s03_axis_tdata (s_data[3]),
    .s03_axis_tlast (s_last[3]),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tlast   (m_tlast)
  );

  // ---------------- checking ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [W:0] exp_q  [$];      // remaining {last,data} beats of the packet being merged
  logic [W:0] cq     [4][$];   // committed, not yet granted beats per channel
  logic [W:0] part_q [4][$];   // packet under construction per channel
  int         pc     [4];      // whole packets waiting per channel
  bit         drop_rest [4];   // discarding the tail of an overflowed packet
  int         out_ch = 0;
  int         rr     = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      int         occ [4];
      logic [W:0] b;
      int         c;
      bit         granted;
      for (int i = 0; i < 4; i++)
        occ[i] = cq[i].size() + part_q[i].size() + ((i == out_ch) ? exp_q.size() : 0);
      // Output side: either a packet is being merged, or pick the next one.
      if (exp_q.size() > 0) begin
        if (m_tready) begin
          b = exp_q.pop_front();
          if (b[W]) rr = (out_ch + 1) % N;
        end
      end else begin
        granted = 1'b0;
        for (int k = 0; k < N; k++) begin
          c = (rr + k) % N;
          if (!granted && pc[c] > 0) begin
            granted = 1'b1;
            out_ch  = c;
            pc[c]--;
            do begin
              b = cq[c].pop_front();
              exp_q.push_back(b);
            end while (!b[W]);
          end
        end
      end
      // Capture side, judged against the occupancy before this edge.
      for (int i = 0; i < N; i++) begin
        if (s_valid[i] && s_ready[i]) begin
          if (drop_rest[i]) begin
            if (s_last[i]) drop_rest[i] = 1'b0;
          end else if (occ[i] >= DEPTH) begin
            part_q[i].delete();
            drop_rest[i] = !s_last[i];
          end else begin
            part_q[i].push_back({s_last[i], s_data[i]});
            if (s_last[i]) begin
              while (part_q[i].size() > 0) cq[i].push_back(part_q[i].pop_front());
              pc[i]++;
            end
          end
        end
      end
    end
  end

  // Output compared against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      logic [W:0] h;
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        check("tvalid", 32'(m_tvalid), 32'd1);
        check("tdata",  32'(m_tdata),  32'(h[W-1:0]));
        check("tlast",  32'(m_tlast),  32'(h[W]));
      end else begin
        check("tvalid_idle", 32'(m_tvalid), 32'd0);
        check("tdata_idle",  32'(m_tdata),  32'd0);
        check("tlast_idle",  32'(m_tlast),  32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) begin
      s_valid[i] = 1'b0;
      s_ready[i] = 1'b0;
      s_last[i]  = 1'b0;
      s_data[i]  = '0;
    end
  endtask

  task automatic send_pkt(input int ch, input int len, input logic [W-1:0] base);
    for (int i = 0; i < len; i++) begin
      s_valid[ch] = 1'b1;
      s_ready[ch] = 1'b1;
      s_data[ch]  = W'(int'(base) + i);
      s_last[ch]  = (i == len - 1);
      @(negedge clk);
    end
    s_valid[ch] = 1'b0;
    s_ready[ch] = 1'b0;
    s_last[ch]  = 1'b0;
    s_data[ch]  = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    idle_inputs();
    m_tready = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tvalid", 32'(m_tvalid), 32'd0);
    check("reset_tdata",  32'(m_tdata),  32'd0);
    check("reset_tlast",  32'(m_tlast),  32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    wait_cycles(2);

    // Single 3-beat packet.
    send_pkt(0, 3, 8'hA0);
    wait_cycles(6);

    // Back-to-back packets on two channels.
    send_pkt(0, 4, 8'hB0);
    send_pkt(1, 2, 8'hC0);
    wait_cycles(15);

    // Stall the output after its first beat.
    send_pkt(0, 3, 8'hD0);
    wait_cycles(2);
    m_tready = 1'b0;
    wait_cycles(5);
    m_tready = 1'b1;
    wait_cycles(8);

    // Two packets stored per channel, then released.
    m_tready = 1'b0;
    send_pkt(0, 2, 8'h10);
    send_pkt(0, 3, 8'h20);
    send_pkt(1, 2, 8'h30);
    send_pkt(1, 2, 8'h40);
    m_tready = 1'b1;
    wait_cycles(25);

    // Over-long packet followed by a short one.
    send_pkt(0, DEPTH + 1, 8'h50);
    send_pkt(0, 2, 8'hE0);
    wait_cycles(10);

    // Valid without ready on s00, traffic on an inactive channel.
    s_valid[0] = 1'b1;
    s_ready[0] = 1'b0;
    s_last[0]  = 1'b1;
    s_data[0]  = 8'h66;
    send_pkt(2, 4, 8'h77);
    idle_inputs();
    wait_cycles(6);

    // Randomized traffic, including overflow and back-pressure.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 4; i++) begin
        s_valid[i] = ($urandom_range(0, 1) == 1);
        s_ready[i] = ($urandom_range(0, 3) != 0);
        s_data[i]  = W'($urandom);
        s_last[i]  = ($urandom_range(0, 5) == 0);
      end
      m_tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    // Drain everything committed.
    idle_inputs();
    m_tready = 1'b1;
    guard    = 0;
    while ((exp_q.size() != 0 || pc[0] != 0 || pc[1] != 0) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(exp_q.size() + pc[0] + pc[1]), 32'd0);
    wait_cycles(4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
